// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    function automatic int mul_steps(input int w, input int s);
        return w / s;
    endfunction

    function automatic int mul_cnt_w(input int w, input int s);
        return $clog2(w / s + 1);
    endfunction

endpackage

// File: rtl/mul_nnbit_pp.sv
// Partial product of the shifted multiplicand and one S-bit multiplier digit.
module mul_nnbit_pp #(
    parameter int DATA_WIDTH = 8,
    parameter int STEP_BITS  = 1
) (
    input  logic [2*DATA_WIDTH-1:0] i_xr,
    input  logic [STEP_BITS-1:0]    i_dig,
    output logic [2*DATA_WIDTH-1:0] o_pp
);

    always_comb begin
        o_pp = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (i_dig[i]) begin
                o_pp = o_pp + (i_xr << i);
            end
        end
    end

endmodule

// File: rtl/mul_nnbit_seq.sv
// Handshaked sequential shift-add multiplier, S multiplier bits per cycle,
// signed or unsigned operands via magnitude/sign decomposition.
module mul_nnbit_seq
    import mul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STEP_BITS  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_signed,
    input  logic [DATA_WIDTH-1:0]   i_num_x,
    input  logic [DATA_WIDTH-1:0]   i_num_y,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [2*DATA_WIDTH-1:0] o_res
);

    localparam int W  = DATA_WIDTH;
    localparam int S  = STEP_BITS;
    localparam int N  = mul_steps(W, S);
    localparam int CW = mul_cnt_w(W, S);

    if ((DATA_WIDTH % STEP_BITS) != 0) begin : g_bad_step
        $error("STEP_BITS must divide DATA_WIDTH");
    end

    mul_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   xr_q, xr_d;
    logic [W-1:0]     yr_q, yr_d;
    logic             sign_q, sign_d;
    logic [2*W-1:0]   res_q, res_d;
    logic [2*W-1:0]   pp;
    logic [2*W-1:0]   sum;
    logic [W-1:0]     mag_x, mag_y;
    logic             last;

    mul_nnbit_pp #(
        .DATA_WIDTH (W),
        .STEP_BITS  (S)
    ) u_pp (
        .i_xr  (xr_q),
        .i_dig (yr_q[S-1:0]),
        .o_pp  (pp)
    );

    // Most-negative operand negates to 2^(W-1), which still fits unsigned.
    assign mag_x = (i_signed & i_num_x[W-1]) ? -i_num_x : i_num_x;
    assign mag_y = (i_signed & i_num_y[W-1]) ? -i_num_y : i_num_y;
    assign sum   = acc_q + pp;
    assign last  = (cnt_q == CW'(N - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_valid) state_d = CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready = i_rst_n & (state_q == IDLE);
        o_valid = (state_q == DONE);
        o_res   = res_q;
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        xr_d   = xr_q;
        yr_d   = yr_q;
        sign_d = sign_q;
        res_d  = res_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    cnt_d  = '0;
                    acc_d  = '0;
                    xr_d   = {{W{1'b0}}, mag_x};
                    yr_d   = mag_y;
                    sign_d = i_signed & (i_num_x[W-1] ^ i_num_y[W-1]);
                end
            end
            CALC: begin
                acc_d = sum;
                xr_d  = xr_q << S;
                yr_d  = yr_q >> S;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    res_d = sign_q ? -sum : sum;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            xr_q   <= '0;
            yr_q   <= '0;
            sign_q <= 1'b0;
            res_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            xr_q   <= xr_d;
            yr_q   <= yr_d;
            sign_q <= sign_d;
            res_q  <= res_d;
        end
    end

endmodule

// File: tb/tb_mul_nnbit_seq.sv
// Directed bench for mul_nnbit_seq at (8,1), (8,4) and (16,2).
module tb_mul_nnbit_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic        sgn = 1'b0;
    logic        ird = 1'b0;
    logic [15:0] nx = '0;
    logic [15:0] ny = '0;

    logic        r0, r1, r2, v0, v1, v2;
    logic [15:0] res0, res1;
    logic [31:0] res2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_nnbit_seq #(.DATA_WIDTH(8), .STEP_BITS(1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .o_ready(r0),
        .i_signed(sgn), .i_num_x(nx[7:0]), .i_num_y(ny[7:0]),
        .o_valid(v0), .i_ready(ird), .o_res(res0)
    );

    mul_nnbit_seq #(.DATA_WIDTH(8), .STEP_BITS(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .o_ready(r1),
        .i_signed(sgn), .i_num_x(nx[7:0]), .i_num_y(ny[7:0]),
        .o_valid(v1), .i_ready(ird), .o_res(res1)
    );

    mul_nnbit_seq #(.DATA_WIDTH(16), .STEP_BITS(2)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .o_ready(r2),
        .i_signed(sgn), .i_num_x(nx), .i_num_y(ny),
        .o_valid(v2), .i_ready(ird), .o_res(res2)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] res_of(input int sel);
        if (sel == 0) return {16'h0, res0};
        if (sel == 1) return {16'h0, res1};
        return res2;
    endfunction

    function automatic logic vld_of(input int sel);
        return (sel == 0) ? v0 : (sel == 1) ? v1 : v2;
    endfunction

    function automatic logic rdy_of(input int sel);
        return (sel == 0) ? r0 : (sel == 1) ? r1 : r2;
    endfunction

    function automatic int lat_of(input int sel);
        return (sel == 1) ? 2 : 8;
    endfunction

    function automatic logic [31:0] model(input int sel, input bit s,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
        longint a, b, p;
        if (sel == 2) begin
            a = s ? longint'($signed(x)) : longint'(x);
            b = s ? longint'($signed(y)) : longint'(y);
            p = a * b;
            return p[31:0];
        end
        a = s ? longint'($signed(x[7:0])) : longint'(x[7:0]);
        b = s ? longint'($signed(y[7:0])) : longint'(y[7:0]);
        p = a * b;
        return {16'h0, p[15:0]};
    endfunction

    task automatic run_op(input int sel, input bit s, input logic [15:0] x,
                          input logic [15:0] y, input logic [31:0] exp,
                          input int stall, input string tag);
        int lat;
        logic [31:0] hold;
        @(negedge clk);
        vld = 1'b1;
        sgn = s;
        nx  = x;
        ny  = y;
        chk({tag, "/rdy_idle"}, rdy_of(sel), 1);
        @(negedge clk);
        sgn = ~s;
        nx  = ~x;
        ny  = ~y;
        lat = 0;
        while (!vld_of(sel) && lat < 40) begin
            chk({tag, "/rdy_busy"}, rdy_of(sel), 0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "/latency"}, lat, lat_of(sel));
        chk({tag, "/res"}, res_of(sel), exp);
        hold = res_of(sel);
        repeat (stall) begin
            @(negedge clk);
            chk({tag, "/stall_vld"}, vld_of(sel), 1);
            chk({tag, "/stall_res"}, res_of(sel), hold);
        end
        vld = 1'b0;
        ird = 1'b1;
        @(negedge clk);
        chk({tag, "/vld_drop"}, vld_of(sel), 0);
        chk({tag, "/res_keep"}, res_of(sel), hold);
        chk({tag, "/rdy_back"}, rdy_of(sel), 1);
        repeat (10) @(negedge clk);
        ird = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst/rdy", r0, 0);
        chk("rst/vld", v0, 0);
        chk("rst/res", res0, 0);
        chk("rst/res16", res2, 0);
        rst_n = 1'b1;
        #1;
        chk("rst/rdy_rel", r0, 1);

        run_op(0, 0, 16'h00FF, 16'h00FF, 32'hFE01, 0, "u255x255");
        run_op(0, 0, 16'h0000, 16'h00AB, 32'h0000, 0, "u0xAB");
        run_op(0, 1, 16'h00FD, 16'h0005, 32'hFFF1, 0, "sm3x5");
        run_op(0, 1, 16'h0080, 16'h0080, 32'h4000, 0, "sm128xm128");
        run_op(0, 1, 16'h0080, 16'h007F, 32'hC080, 0, "sm128x127");
        run_op(0, 1, 16'h00FF, 16'h0001, 32'hFFFF, 0, "sFFx01");
        run_op(0, 0, 16'h00FF, 16'h0001, 32'h00FF, 0, "uFFx01");
        run_op(1, 0, 16'h00C8, 16'h0003, 32'h0258, 0, "s4_200x3");
        run_op(2, 1, 16'hFFFF, 16'hFFFF, 32'h0001, 0, "w16_m1xm1");
        run_op(0, 0, 16'h00FF, 16'h00FF, 32'hFE01, 5, "bp_255x255");

        @(negedge clk);
        vld = 1'b1;
        sgn = 1'b0;
        nx  = 16'h0011;
        ny  = 16'h0013;
        @(posedge clk);
        vld = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst/vld", v0, 0);
        chk("mid_rst/res", res0, 0);
        chk("mid_rst/rdy", r0, 0);
        #1 rst_n = 1'b1;
        run_op(0, 0, 16'h0007, 16'h0006, 32'h002A, 0, "post_rst_7x6");

        for (int i = 0; i < 120; i++) begin
            int sel;
            bit s;
            logic [15:0] x, y;
            sel = $urandom_range(0, 2);
            s   = 1'($urandom_range(0, 1));
            x   = 16'($urandom);
            y   = 16'($urandom);
            run_op(sel, s, x, y, model(sel, s, x, y),
                   $urandom_range(0, 3), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
